vc_link_tx: RTL and testbench

Transmit-side link stage of the router output port. It collects flits from up to NumVirtChn per-VC sources and arbitrates among them with fixed priority. It can hold one VC for a whole packet (wormhole lock). The winning flit is launched through a single registered output onto the link that feeds the next router's input datapath, where the flit is demultiplexed by its vc_id.

---
 rtl/vc_link_tx_if.sv | 42 ++++
 rtl/vc_link_tx.sv | 141 ++++++++++++++
 tb/tb_vc_link_tx.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/vc_link_tx_if.sv
// vc_link_tx_if: link-stage bundle for vc_link_tx.
//   vc_req_i    per-VC flit request (fdata, valid; vc_id unused on input)
//   vc_last_i   per-VC tail marker, qualified by vc_req_i[i].valid
//   vc_resp_o   per-VC ready
//   fout_req_o  registered link flit (fdata, valid, vc_id)
//   fout_resp_i link ready from downstream
//   lock_o      packet lock held
//   lock_vc_o   locked VC index, 0 when unlocked
// Modports: master = flit sources / downstream sink side, slave = vc_link_tx.
interface vc_link_tx_if #(
    parameter int unsigned NumVc = 4,
    parameter int unsigned VcW   = 2,
    parameter int unsigned DataW = 8
);
    typedef struct packed {
        logic [DataW-1:0] fdata;
        logic             valid;
        logic [VcW-1:0]   vc_id;
    } s_flit_req_t;

    typedef struct packed {
        logic ready;
    } s_flit_resp_t;

    s_flit_req_t      vc_req_i  [NumVc];
    logic [NumVc-1:0] vc_last_i;
    s_flit_resp_t     vc_resp_o [NumVc];
    s_flit_req_t      fout_req_o;
    s_flit_resp_t     fout_resp_i;
    logic             lock_o;
    logic [VcW-1:0]   lock_vc_o;

    modport master (
        output vc_req_i, vc_last_i, fout_resp_i,
        input  vc_resp_o, fout_req_o, lock_o, lock_vc_o
    );

    modport slave (
        input  vc_req_i, vc_last_i, fout_resp_i,
        output vc_resp_o, fout_req_o, lock_o, lock_vc_o
    );
endinterface

// File: rtl/vc_link_tx.sv
// vc_link_tx: transmit-side link stage of a router output port.
// Fixed-priority arbitration among NumVc flit sources into a single
// registered output stage; optional wormhole lock holds one VC for a
// whole packet.
// Ports:
//   clk   rising-edge clock
//   arst  asynchronous reset, active-low
//   link  vc_link_tx_if.slave (per-VC requests/readies, output flit, lock)
// Parameters:
//   NumVc     number of VC sources
//   VcW       vc_id width
//   DataW     flit payload width
//   PriorMode 0 = HighPriority (index 0 wins), 1 = ZeroLowPrior (highest index wins)
// Build option: define VC_LINK_TX_PKT_LOCK_EN to enable the packet lock FSM;
// without it arbitration is per flit, vc_last_i is ignored, lock outputs are 0.
module vc_link_tx #(
    parameter int unsigned NumVc     = 4,
    parameter int unsigned VcW       = 2,
    parameter int unsigned DataW     = 8,
    parameter int unsigned PriorMode = 0
) (
    input  logic         clk,
    input  logic         arst,
    vc_link_tx_if.slave  link
);
    localparam int unsigned ZeroLowPrior = 1;

    logic             locked;
    logic [VcW-1:0]   lock_vc;
    logic [NumVc-1:0] cand;
    logic             win_vld;
    logic [VcW-1:0]   win_idx;
    logic             free;
    logic             grant_ok;
    logic             xfer;

    // Stage can take a flit when empty or being drained this cycle.
    // Readies are forced low while reset is asserted.
    assign free     = !link.fout_req_o.valid || link.fout_resp_i.ready;
    assign grant_ok = free && arst;
    assign xfer     = win_vld && grant_ok;

    always_comb begin
        cand    = '0;
        win_vld = 1'b0;
        win_idx = '0;
        for (int unsigned i = 0; i < NumVc; i++) begin
            cand[i] = link.vc_req_i[i].valid && (!locked || lock_vc == VcW'(i));
        end
        // Ascending scan: ZeroLowPrior keeps overwriting (last hit wins),
        // otherwise the first hit sticks.
        for (int unsigned i = 0; i < NumVc; i++) begin
            if (cand[i] && (PriorMode == ZeroLowPrior || !win_vld)) begin
                win_vld = 1'b1;
                win_idx = VcW'(i);
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NumVc; i++) begin
            link.vc_resp_o[i] = '0;
        end
        for (int unsigned i = 0; i < NumVc; i++) begin
            if (win_vld && win_idx == VcW'(i)) begin
                link.vc_resp_o[i].ready = grant_ok;
            end
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            link.fout_req_o <= '0;
        end else if (xfer) begin
            link.fout_req_o.fdata <= link.vc_req_i[win_idx].fdata;
            link.fout_req_o.valid <= 1'b1;
            link.fout_req_o.vc_id <= win_idx;
        end else if (free) begin
            link.fout_req_o.valid <= 1'b0;
        end
    end

`ifdef VC_LINK_TX_PKT_LOCK_EN
    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } lock_state_e;

    lock_state_e    state_q, state_d;
    logic [VcW-1:0] lock_vc_q, lock_vc_d;

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q   <= ST_IDLE;
            lock_vc_q <= '0;
        end else begin
            state_q   <= state_d;
            lock_vc_q <= lock_vc_d;
        end
    end

    // While locked the only possible winner is lock_vc_q, so win_idx
    // identifies the locked VC on any transfer.
    always_comb begin
        state_d   = state_q;
        lock_vc_d = lock_vc_q;
        case (state_q)
            ST_IDLE: begin
                if (xfer && !link.vc_last_i[win_idx]) begin
                    state_d   = ST_LOCKED;
                    lock_vc_d = win_idx;
                end
            end
            ST_LOCKED: begin
                if (xfer && link.vc_last_i[win_idx]) begin
                    state_d   = ST_IDLE;
                    lock_vc_d = '0;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                lock_vc_d = '0;
            end
        endcase
    end

    assign locked         = (state_q == ST_LOCKED);
    assign lock_vc        = lock_vc_q;
    assign link.lock_o    = locked;
    assign link.lock_vc_o = lock_vc_q;
`else
    logic last_unused;

    assign last_unused    = ^link.vc_last_i;
    assign locked         = 1'b0;
    assign lock_vc        = '0;
    assign link.lock_o    = 1'b0;
    assign link.lock_vc_o = '0;
`endif

endmodule

// File: tb/tb_vc_link_tx.sv
// tb_vc_link_tx: directed self-checking bench for vc_link_tx.
// u_dut runs PriorMode=1 (ZeroLowPrior), u_hi runs the default PriorMode=0.
// Expectations branch on VC_LINK_TX_PKT_LOCK_EN where lock behaviour differs.
module tb_vc_link_tx;
    logic clk;
    logic arst;

    int unsigned n_chk;
    int unsigned n_fail;

    vc_link_tx_if #(.NumVc(4), .VcW(2), .DataW(8)) lnk ();
    vc_link_tx_if #(.NumVc(4), .VcW(2), .DataW(8)) lnk_hi ();

    vc_link_tx #(.NumVc(4), .VcW(2), .DataW(8), .PriorMode(1)) u_dut (
        .clk  (clk),
        .arst (arst),
        .link (lnk)
    );

    vc_link_tx #(.NumVc(4), .VcW(2), .DataW(8), .PriorMode(0)) u_hi (
        .clk  (clk),
        .arst (arst),
        .link (lnk_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected packed output flit: {fdata, valid=1, vc_id}
    function automatic logic [10:0] exp_flit(input logic [7:0] d, input logic [1:0] v);
        return {d, 1'b1, v};
    endfunction

    function automatic logic [3:0] rdy_vec();
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = lnk.vc_resp_o[i].ready;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_all();
        for (int i = 0; i < 4; i++) begin
            lnk.vc_req_i[i]    = '0;
            lnk_hi.vc_req_i[i] = '0;
        end
        lnk.vc_last_i          = '0;
        lnk_hi.vc_last_i       = '0;
        lnk.fout_resp_i.ready    = 1'b1;
        lnk_hi.fout_resp_i.ready = 1'b1;
    endtask

    task automatic drv(input int i, input logic [7:0] d, input logic l);
        lnk.vc_req_i[i].valid = 1'b1;
        lnk.vc_req_i[i].fdata = d;
        lnk.vc_req_i[i].vc_id = '0;
        lnk.vc_last_i[i]      = l;
    endtask

    task automatic stop(input int i);
        lnk.vc_req_i[i].valid = 1'b0;
        lnk.vc_last_i[i]      = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got still running, expected finished");
        $fatal(1);
    end

    initial begin
        n_chk  = 0;
        n_fail = 0;
        arst   = 1'b0;
        clr_all();

        // ---- reset, then async reset mid-packet ----
        drv(0, 8'h01, 1'b0);
        repeat (3) tick();
        chk("rst_fout", 32'(lnk.fout_req_o), 32'h0);
        chk("rst_rdy", 32'(rdy_vec()), 32'h0);
        chk("rst_lock", 32'(lnk.lock_o), 32'h0);
        chk("rst_lock_vc", 32'(lnk.lock_vc_o), 32'h0);
        arst = 1'b1;
        #1;
        chk("rel_rdy", 32'(rdy_vec()), 32'h1);
        tick();
        chk("rel_flit0", 32'(lnk.fout_req_o), 32'(exp_flit(8'h01, 2'd0)));
`ifdef VC_LINK_TX_PKT_LOCK_EN
        chk("rel_lock", 32'(lnk.lock_o), 32'h1);
`else
        chk("rel_lock", 32'(lnk.lock_o), 32'h0);
`endif
        drv(0, 8'h02, 1'b0);
        #2;
        arst = 1'b0;
        #1;
        chk("arst_vld", 32'(lnk.fout_req_o.valid), 32'h0);
        chk("arst_lock", 32'(lnk.lock_o), 32'h0);
        chk("arst_lock_vc", 32'(lnk.lock_vc_o), 32'h0);
        stop(0);
        drv(1, 8'h11, 1'b1);
        #1;
        chk("arst_rdy", 32'(rdy_vec()), 32'h0);
        arst = 1'b1;
        #1;
        chk("rel2_rdy", 32'(rdy_vec()), 32'h2);
        tick();
        chk("rel2_flit", 32'(lnk.fout_req_o), 32'(exp_flit(8'h11, 2'd1)));
        chk("rel2_lock", 32'(lnk.lock_o), 32'h0);
        stop(1);
        tick();
        chk("rel2_idle", 32'(lnk.fout_req_o.valid), 32'h0);

        // ---- priority, ZeroLowPrior: VC2 before VC0 ----
        drv(0, 8'hA0, 1'b1);
        drv(2, 8'hC2, 1'b1);
        #1;
        chk("prio_rdy", 32'(rdy_vec()), 32'h4);
        tick();
        chk("prio_first", 32'(lnk.fout_req_o), 32'(exp_flit(8'hC2, 2'd2)));
        stop(2);
        #1;
        chk("prio_rdy2", 32'(rdy_vec()), 32'h1);
        tick();
        chk("prio_second", 32'(lnk.fout_req_o), 32'(exp_flit(8'hA0, 2'd0)));
        stop(0);
        tick();
        chk("prio_idle", 32'(lnk.fout_req_o.valid), 32'h0);

        // ---- priority, HighPriority instance: VC0 before VC2 ----
        lnk_hi.vc_req_i[0] = '{fdata: 8'hA0, valid: 1'b1, vc_id: 2'd0};
        lnk_hi.vc_req_i[2] = '{fdata: 8'hC2, valid: 1'b1, vc_id: 2'd0};
        lnk_hi.vc_last_i   = 4'b0101;
        tick();
        chk("hi_first", 32'(lnk_hi.fout_req_o), 32'(exp_flit(8'hA0, 2'd0)));
        lnk_hi.vc_req_i[0].valid = 1'b0;
        tick();
        chk("hi_second", 32'(lnk_hi.fout_req_o), 32'(exp_flit(8'hC2, 2'd2)));
        lnk_hi.vc_req_i[2].valid = 1'b0;
        tick();
        chk("hi_idle", 32'(lnk_hi.fout_req_o.valid), 32'h0);

        // ---- wormhole: VC0 3-flit packet, VC1 joins after flit 1 ----
        drv(0, 8'h31, 1'b0);
        tick();
        chk("wh_f1", 32'(lnk.fout_req_o), 32'(exp_flit(8'h31, 2'd0)));
        drv(0, 8'h32, 1'b0);
        drv(1, 8'h41, 1'b1);
        #1;
`ifdef VC_LINK_TX_PKT_LOCK_EN
        chk("wh_lock1", 32'(lnk.lock_o), 32'h1);
        chk("wh_lockvc1", 32'(lnk.lock_vc_o), 32'h0);
        chk("wh_rdy1", 32'(rdy_vec()), 32'h1);
        tick();
        chk("wh_f2", 32'(lnk.fout_req_o), 32'(exp_flit(8'h32, 2'd0)));
        drv(0, 8'h33, 1'b1);
        #1;
        chk("wh_lock2", 32'(lnk.lock_o), 32'h1);
        chk("wh_rdy2", 32'(rdy_vec()), 32'h1);
        tick();
        chk("wh_f3", 32'(lnk.fout_req_o), 32'(exp_flit(8'h33, 2'd0)));
        chk("wh_unlock", 32'(lnk.lock_o), 32'h0);
        stop(0);
        #1;
        chk("wh_rdy3", 32'(rdy_vec()), 32'h2);
        tick();
        chk("wh_vc1", 32'(lnk.fout_req_o), 32'(exp_flit(8'h41, 2'd1)));
        stop(1);
`else
        chk("nl_lock1", 32'(lnk.lock_o), 32'h0);
        chk("nl_rdy1", 32'(rdy_vec()), 32'h2);
        tick();
        chk("nl_vc1", 32'(lnk.fout_req_o), 32'(exp_flit(8'h41, 2'd1)));
        chk("nl_lock2", 32'(lnk.lock_o), 32'h0);
        stop(1);
        #1;
        chk("nl_rdy2", 32'(rdy_vec()), 32'h1);
        tick();
        chk("nl_f2", 32'(lnk.fout_req_o), 32'(exp_flit(8'h32, 2'd0)));
        drv(0, 8'h33, 1'b1);
        tick();
        chk("nl_f3", 32'(lnk.fout_req_o), 32'(exp_flit(8'h33, 2'd0)));
        chk("nl_lock3", 32'(lnk.lock_o), 32'h0);
        stop(0);
`endif
        tick();
        chk("wh_idle", 32'(lnk.fout_req_o.valid), 32'h0);

        // ---- back-pressure with 0xA5 held for 4 cycles ----
        drv(2, 8'hA5, 1'b1);
        tick();
        stop(2);
        drv(1, 8'h5A, 1'b1);
        lnk.fout_resp_i.ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c != 0) tick();
            else #1;
            chk("bp_hold", 32'(lnk.fout_req_o), 32'(exp_flit(8'hA5, 2'd2)));
            chk("bp_rdy", 32'(rdy_vec()), 32'h0);
        end
        lnk.fout_resp_i.ready = 1'b1;
        #1;
        chk("bp_rel_rdy", 32'(rdy_vec()), 32'h2);
        tick();
        chk("bp_next", 32'(lnk.fout_req_o), 32'(exp_flit(8'h5A, 2'd1)));
        stop(1);
        tick();
        chk("bp_idle", 32'(lnk.fout_req_o.valid), 32'h0);

        // ---- streaming: 16 flits on VC3 ----
        drv(3, 8'h80, 1'b0);
        for (int k = 0; k < 16; k++) begin
            tick();
            chk("stream", 32'(lnk.fout_req_o), 32'(exp_flit(8'(8'h80 + k), 2'd3)));
            if (k == 15) stop(3);
            else drv(3, 8'(8'h81 + k), (k == 14));
        end
        tick();
        chk("stream_idle", 32'(lnk.fout_req_o.valid), 32'h0);
        chk("stream_lock", 32'(lnk.lock_o), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
